// File: rtl/pdm_deserializer_mc_pkg.sv
// Shared types for the multi-channel PDM deserializer: FSM states, channel tags, FIFO entry.
package pdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic CHAN_L = 1'b0;
    localparam logic CHAN_R = 1'b1;

    // Widest word the FIFO entry can carry; narrower words sit in the low bits.
    localparam int unsigned PDM_MAX_W = 32;

    typedef struct packed {
        logic                 chan;
        logic [PDM_MAX_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pdm_deserializer_mc_clk_gen.sv
// PDM clock divider: generates the microphone clock and the two capture ticks.
module pdm_clk_gen #(
    parameter int unsigned CLK_DIV = 100
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run_i,
    input  logic stop_i,
    output logic pdm_clk_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] HALF    = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] HALF_M1 = DW'(CLK_DIV / 2 - 1);
    localparam logic [DW-1:0] LAST    = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    // Divider is forced back to 0 on the last RUN cycle so IDLE always sees 0.
    always_comb begin
        div_d = '0;
        if (run_i && !stop_i) begin
            div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pdm_clk_o   = run_i && (div_q < HALF);
    assign fall_tick_o = run_i && (div_q == HALF_M1);
    assign rise_tick_o = run_i && (div_q == LAST);

endmodule

// File: rtl/pdm_deserializer_mc.sv
// Mono/stereo PDM capture, word packing and output FIFO with drop detection.
// Optional drop counter port ovf_count_o enabled by defining PDM_DESER_OVF_CNT_EN.
module pdm_deserializer_mc
    import pdm_pkg::*;
#(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned CLK_DIV    = 100,
    parameter int unsigned STEREO     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic              pdm_data_i,
    output logic              pdm_clk_o,
    output logic              pdm_lrsel_o,
    output logic [WORD_W-1:0] data_o,
    output logic              chan_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overflow_o,
    input  logic              clear_ovf_i
`ifdef PDM_DESER_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_count_o
`endif
);
    localparam int unsigned NCH = (STEREO != 0) ? 2 : 1;
    localparam int unsigned CW  = $clog2(WORD_W);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(WORD_W - 1);

    state_e state_q, state_d;
    logic   fall_tick, rise_tick;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable_i)  state_d = RUN;
            RUN:  if (!enable_i) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clock       (clock),
        .reset_n     (reset_n),
        .run_i       (state_q == RUN),
        .stop_i      (!enable_i),
        .pdm_clk_o   (pdm_clk_o),
        .fall_tick_o (fall_tick),
        .rise_tick_o (rise_tick)
    );

    assign pdm_lrsel_o = 1'b0;

    logic [NCH-1:0]    push_vec;
    logic [WORD_W-1:0] push_word [NCH];

    for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
        logic [WORD_W-1:0] shift_q, shift_d, word;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic              tick, push;

        assign tick = (ch == 0) ? fall_tick : rise_tick;
        assign word = {shift_q[WORD_W-2:0], pdm_data_i};

        always_comb begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
            push    = 1'b0;
            if (state_q == IDLE) begin
                shift_d = '0;
                cnt_d   = '0;
            end else if (tick) begin
                shift_d = word;
                if (cnt_q == BIT_LAST) begin
                    push  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else begin
                shift_q <= shift_d;
                cnt_q   <= cnt_d;
            end
        end

        assign push_vec[ch]  = push;
        assign push_word[ch] = word;
    end

    fifo_entry_t mem_q [FIFO_DEPTH];
    fifo_entry_t new_entry, head;
    logic [AW:0] wr_q, rd_q;
    logic        push, pop, full, accept, drop, ovf_q;
    logic        unused_head;

    always_comb begin
        new_entry = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (push_vec[ch]) begin
                new_entry.chan              = (ch == 0) ? CHAN_L : CHAN_R;
                new_entry.data[WORD_W-1:0] = push_word[ch];
            end
        end
    end

    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push   = |push_vec;
    assign pop    = valid_o && ready_i;
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem_q[wr_q[AW-1:0]] <= new_entry;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign head        = mem_q[rd_q[AW-1:0]];
    assign data_o      = head.data[WORD_W-1:0];
    assign chan_o      = head.chan;
    assign valid_o     = (wr_q != rd_q);
    assign overflow_o  = ovf_q;
    assign unused_head = ^head.data;

`ifdef PDM_DESER_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && clear_ovf_i) begin
            ovf_cnt_d = 16'd1;
        end else if (clear_ovf_i) begin
            ovf_cnt_d = '0;
        end else if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_pdm_deserializer_mc.sv
// Bench: mono and stereo instances driven in lockstep, checked against a queue-level model.
module tb_pdm_deserializer_mc;
    localparam int CLK_DIV = 4;
    localparam int WW      = 8;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst_n, en, din, clr, rdy_m, rdy_s;
    logic [1:0] pclk_w, lrsel_w, chan_w, valid_w, ovf_w;
    logic [7:0] data_w [2];
`ifdef PDM_DESER_OVF_CNT_EN
    logic [15:0] ocnt_w [2];
`endif

    always #5 clk = ~clk;

    pdm_deserializer_mc #(.WORD_W(WW), .CLK_DIV(CLK_DIV), .STEREO(0), .FIFO_DEPTH(DEPTH)) u_mono (
        .clock(clk), .reset_n(rst_n), .enable_i(en), .pdm_data_i(din),
        .pdm_clk_o(pclk_w[0]), .pdm_lrsel_o(lrsel_w[0]), .data_o(data_w[0]), .chan_o(chan_w[0]),
        .valid_o(valid_w[0]), .ready_i(rdy_m), .overflow_o(ovf_w[0]), .clear_ovf_i(clr)
`ifdef PDM_DESER_OVF_CNT_EN
        , .ovf_count_o(ocnt_w[0])
`endif
    );

    pdm_deserializer_mc #(.WORD_W(WW), .CLK_DIV(CLK_DIV), .STEREO(1), .FIFO_DEPTH(DEPTH)) u_st (
        .clock(clk), .reset_n(rst_n), .enable_i(en), .pdm_data_i(din),
        .pdm_clk_o(pclk_w[1]), .pdm_lrsel_o(lrsel_w[1]), .data_o(data_w[1]), .chan_o(chan_w[1]),
        .valid_o(valid_w[1]), .ready_i(rdy_s), .overflow_o(ovf_w[1]), .clear_ovf_i(clr)
`ifdef PDM_DESER_OVF_CNT_EN
        , .ovf_count_o(ocnt_w[1])
`endif
    );

    int chk = 0;
    int pass = 0;
    int cyc = 0;

    task automatic check(input string nm, input int act, input int exp);
        chk++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Model: k = cycles since RUN entry, per-channel accumulators, FIFO as a list (index 0 = head).
    bit mrun [2];
    int mk   [2];
    int macc [2][2];
    int mn   [2][2];
    int mf   [2][DEPTH];
    int mcnt [2];
    bit movf [2];
    int mocnt[2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mrun[i] = 0; mk[i] = 0; mcnt[i] = 0; movf[i] = 0; mocnt[i] = 0;
            for (int c = 0; c < 2; c++) begin macc[i][c] = 0; mn[i][c] = 0; end
        end
    endfunction

    function automatic void model_edge(input int i, input bit rdy);
        bit pop = (mcnt[i] > 0) && rdy;
        bit drop = 0;
        int pushw = -1;
        if (mrun[i]) begin
            for (int c = 0; c < 2; c++) begin
                if ((c == 0 && mk[i] % CLK_DIV == CLK_DIV/2 - 1) ||
                    (c == 1 && i == 1 && mk[i] % CLK_DIV == CLK_DIV - 1)) begin
                    macc[i][c] = (macc[i][c] * 2 + int'(din)) % 256;
                    mn[i][c]++;
                    if (mn[i][c] == WW) begin
                        pushw = c * 256 + macc[i][c];
                        mn[i][c] = 0; macc[i][c] = 0;
                    end
                end
            end
            mk[i]++;
            if (!en) begin
                mrun[i] = 0;
                for (int c = 0; c < 2; c++) begin macc[i][c] = 0; mn[i][c] = 0; end
            end
        end else if (en) begin
            mrun[i] = 1; mk[i] = 0;
        end
        if (pop) begin
            for (int e = 0; e < DEPTH - 1; e++) mf[i][e] = mf[i][e+1];
            mcnt[i]--;
        end
        if (pushw >= 0) begin
            if (mcnt[i] < DEPTH) begin mf[i][mcnt[i]] = pushw; mcnt[i]++; end
            else drop = 1;
        end
        if (drop) movf[i] = 1;
        else if (clr) movf[i] = 0;
        if (drop && clr) mocnt[i] = 1;
        else if (clr) mocnt[i] = 0;
        else if (drop && mocnt[i] < 65535) mocnt[i]++;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_edge(0, rdy_m);
            model_edge(1, rdy_s);
        end
    end

    always @(posedge clk) cyc++;

    int log_m[$];
    int log_s[$];
    int logc_s[$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("valid[%0d]", i), valid_w[i], mcnt[i] > 0);
            check($sformatf("overflow[%0d]", i), ovf_w[i], movf[i]);
            check($sformatf("pdm_clk[%0d]", i), pclk_w[i],
                  mrun[i] && (mk[i] % CLK_DIV) < CLK_DIV/2);
            check($sformatf("lrsel[%0d]", i), lrsel_w[i], 0);
            if (mcnt[i] > 0) begin
                check($sformatf("data[%0d]", i), data_w[i], mf[i][0] % 256);
                check($sformatf("chan[%0d]", i), chan_w[i], mf[i][0] / 256);
            end
`ifdef PDM_DESER_OVF_CNT_EN
            check($sformatf("ovf_count[%0d]", i), ocnt_w[i], mocnt[i]);
`endif
        end
        if (valid_w[0] && rdy_m) log_m.push_back({23'd0, chan_w[0], data_w[0]});
        if (valid_w[1] && rdy_s) begin
            log_s.push_back({23'd0, chan_w[1], data_w[1]});
            logc_s.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit [7:0] lw[$];
    bit [7:0] rw[$];
    int first_v;

    // L bit held over divider phases 0..1, R bit over phases 2..3.
    task automatic stream(input int nbits, input int pop_j, input int rst_j);
        first_v = -1;
        en = 1'b1;
        step();
        for (int j = 0; j < nbits * CLK_DIV; j++) begin
            int b = j / CLK_DIV;
            int w = b / WW;
            int bi = WW - 1 - b % WW;
            bit [7:0] lv, rv;
            lv = (w < lw.size()) ? lw[w] : 8'h00;
            rv = (w < rw.size()) ? rw[w] : 8'h00;
            din = (j % CLK_DIV < CLK_DIV/2) ? lv[bi] : rv[bi];
            if (pop_j >= 0) rdy_m = (j == pop_j);
            if (first_v < 0 && valid_w[0]) first_v = j;
            if (j == rst_j) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("rst_valid[%0d]", i), valid_w[i], 0);
                    check($sformatf("rst_data[%0d]", i), data_w[i], 0);
                    check($sformatf("rst_chan[%0d]", i), chan_w[i], 0);
                    check($sformatf("rst_ovf[%0d]", i), ovf_w[i], 0);
                    check($sformatf("rst_pclk[%0d]", i), pclk_w[i], 0);
                end
                rst_n = 1'b1;
                break;
            end
            step();
        end
        en = 1'b0;
        din = 1'b0;
        step();
    endtask

    task automatic drain_and_clear();
        rdy_m = 1'b1; rdy_s = 1'b1;
        repeat (8) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
    endtask

    initial begin
        int n0, d;
        rst_n = 1'b0; en = 1'b0; din = 1'b0; clr = 1'b0; rdy_m = 1'b0; rdy_s = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("init_valid[%0d]", i), valid_w[i], 0);
            check($sformatf("init_data[%0d]", i), data_w[i], 0);
            check($sformatf("init_pclk[%0d]", i), pclk_w[i], 0);
        end
        step(); step();
        rst_n = 1'b1;
        step();

        // Basic mono timing plus stereo ordering.
        rdy_m = 1'b1; rdy_s = 1'b1;
        lw = '{8'hA5, 8'h3C};
        rw = '{8'h5A, 8'hC3};
        stream(16, -1, -1);
        repeat (4) step();
        check("first_valid_cycle", first_v, 30);
        check("mono_w0", log_m[0], 8'hA5);
        check("mono_w1", log_m[1], 8'h3C);
        check("st_count", log_s.size(), 4);
        check("st_L", log_s[2], 8'h3C);
        check("st_R", log_s[3], 256 + 8'hC3);
        check("st_R_gap", logc_s[3] - logc_s[2], 2);

        // Back-pressure: fifth word dropped, head held.
        rdy_m = 1'b0; rdy_s = 1'b0;
        lw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rw = '{8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        n0 = log_m.size();
        stream(40, -1, -1);
        step();
        check("ovf_set", ovf_w[0], 1);
        check("ovf_head", data_w[0], 8'h11);
`ifdef PDM_DESER_OVF_CNT_EN
        check("ovf_count_one", ocnt_w[0], 1);
`endif
        drain_and_clear();
        check("ovf_cleared", ovf_w[0], 0);
        check("drain_order", log_m[n0 + 3], 8'h44);
        check("drain_len", log_m.size() - n0, 4);

        // Pop coincident with the push into a full FIFO.
        rdy_s = 1'b1;
        lw = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        n0 = log_m.size();
        stream(40, 157, -1);
        step();
        check("coinc_no_ovf", ovf_w[0], 0);
        check("coinc_head", data_w[0], 8'h02);
        drain_and_clear();
        for (int e = 0; e < 5; e++) check($sformatf("coinc_order%0d", e), log_m[n0 + e], e + 1);

        // Partial word discarded on disable; FIFO drainable in IDLE.
        rdy_m = 1'b0;
        lw = '{8'hC6, 8'h7E, 8'hFF};
        stream(21, -1, -1);
        repeat (3) step();
        check("idle_valid", valid_w[0], 1);
        check("idle_head", data_w[0], 8'hC6);
        rdy_m = 1'b1;
        repeat (2) step();
        lw = '{8'h96};
        stream(8, -1, -1);
        repeat (3) step();
        d = log_m.size();
        check("partial_prev", log_m[d - 2], 8'h7E);
        check("partial_new", log_m[d - 1], 8'h96);

        // Reset mid-word with two words queued.
        rdy_m = 1'b0; rdy_s = 1'b0;
        lw = '{8'h12, 8'h34, 8'h56};
        rw = '{8'h9A, 8'hBC, 8'hDE};
        stream(21, -1, 80);
        n0 = log_m.size();
        rdy_m = 1'b1; rdy_s = 1'b1;
        lw = '{8'h81};
        stream(8, -1, -1);
        repeat (3) step();
        check("post_rst_first_valid", first_v, 30);
        check("post_rst_len", log_m.size() - n0, 1);
        check("post_rst_word", log_m[log_m.size() - 1], 8'h81);

        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
